// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader and the core-side instruction memory.
package instruction_loader_pkg;

  localparam int WORD_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 7;
  localparam int BYTES_PER_WORD = WORD_W_DEF / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  function automatic int bytes_per_word(input int word_w);
    return word_w / 8;
  endfunction

endpackage

// File: rtl/instruction_loader_assembler.sv
// Big-endian byte shift register with a byte counter; word_full flags the shift that completes a word.
module word_assembler
  import instruction_loader_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              clear,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word_out,
  output logic              word_full
);

  localparam int BPW   = bytes_per_word(WORD_W);
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [WORD_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;

  assign word_out  = r_shift;
  assign word_full = shift_en && (r_cnt == CNT_W'(BPW - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (shift_en) begin
      r_shift <= {r_shift[WORD_W-9:0], byte_in};
      r_cnt   <= word_full ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Streams a header count plus big-endian words into instruction memory, then releases the core.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic [ADDR_W-1:0] cantidad_instrucciones,
  output logic              load_done,
  output logic              load_err
);

  state_t            r_state;
  logic              r_in_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_n;
  logic              r_cpu_reset;
  logic [ADDR_W-1:0] r_cnt_out;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic              w_shift_en;
  logic              w_clear;
  logic              w_word_full;
  logic [WORD_W-1:0] w_word;
  logic [ADDR_W-1:0] w_hdr_n;
  logic              w_hdr_bad;
  logic [ADDR_W-1:0] w_idx_next;

  assign w_accept   = in_valid && r_in_ready;
  assign w_shift_en = w_accept && (r_state == LOAD);
  assign w_clear    = (r_state == WRITE);
  assign w_hdr_n    = in_data[ADDR_W-1:0];
  assign w_hdr_bad  = (|(in_data >> ADDR_W)) || (w_hdr_n == '0);
  assign w_idx_next = r_idx + ADDR_W'(1);

  word_assembler #(.WORD_W(WORD_W)) u_asm (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (w_shift_en),
    .clear     (w_clear),
    .byte_in   (in_data),
    .word_out  (w_word),
    .word_full (w_word_full)
  );

  // The assembled word and word index are both registers that stay stable through WRITE,
  // so they drive the memory port directly.
  assign in_ready               = r_in_ready;
  assign mem_we                 = r_mem_we;
  assign mem_addr               = r_idx;
  assign mem_wdata              = w_word;
  assign cpu_reset              = r_cpu_reset;
  assign cantidad_instrucciones = r_cnt_out;
  assign load_done              = r_done;
  assign load_err               = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_idx       <= '0;
      r_n         <= '0;
      r_cpu_reset <= 1'b1;
      r_cnt_out   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            if (w_hdr_bad) begin
              r_state    <= ERR;
              r_in_ready <= 1'b0;
              r_err      <= 1'b1;
            end else begin
              r_n     <= w_hdr_n;
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (w_word_full) begin
            r_state    <= WRITE;
            r_in_ready <= 1'b0;
            r_mem_we   <= 1'b1;
          end
        end
        WRITE: begin
          r_mem_we <= 1'b0;
          r_idx    <= w_idx_next;
          if (w_idx_next == r_n) begin
            r_state     <= DONE;
            r_cpu_reset <= 1'b0;
            r_done      <= 1'b1;
            r_cnt_out   <= r_n;
          end else begin
            r_state    <= LOAD;
            r_in_ready <= 1'b1;
          end
        end
        DONE, ERR: begin
          r_in_ready <= 1'b0;
          r_mem_we   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: nominal, bad headers, gaps, backpressure, reset abort, max size.
module tb_instruction_loader;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 7;
  localparam int LIM    = 200;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              cpu_reset;
  logic [ADDR_W-1:0] cantidad_instrucciones;
  logic              load_done;
  logic              load_err;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int stall_cnt = 0;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [WORD_W-1:0] wr_data[$];
  logic [WORD_W-1:0] exp_d[$];

  instruction_loader #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .in_data                (in_data),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .mem_we                 (mem_we),
    .mem_addr               (mem_addr),
    .mem_wdata              (mem_wdata),
    .cpu_reset              (cpu_reset),
    .cantidad_instrucciones (cantidad_instrucciones),
    .load_done              (load_done),
    .load_err               (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  always @(posedge clk) begin
    if (!reset && in_valid && in_ready === 1'b1) acc_cnt++;
    if (!reset && in_valid && in_ready === 1'b0 && load_done === 1'b0 && load_err === 1'b0)
      stall_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    exp_d.delete();
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [7:0] b);
    int t;
    in_data = b;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < LIM) begin
      @(negedge clk);
      t++;
    end
    if (t == LIM) chk("send_ready_timeout", {63'd0, in_ready}, 64'd1);
    else @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
    exp_d.push_back(w);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwrites"}, 64'(wr_data.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < wr_data.size(); i++) begin
      chk({tag, "_addr"}, 64'(wr_addr[i]), 64'(i));
      chk({tag, "_data"}, 64'(wr_data[i]), 64'(exp_d[i]));
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
    chk({tag, "_cantidad"}, 64'(cantidad_instrucciones), 64'd0);
    chk({tag, "_done"}, 64'(load_done), 64'd0);
    chk({tag, "_err"}, 64'(load_err), 64'd0);
  endtask

  initial begin
    int a0;
    int s0;
    logic [31:0] w;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;

    // Nominal two-word load with continuous valid
    send(8'h02);
    send_word(32'h12345678);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    exp_d.push_back(32'hAABBCCDD);
    chk("nom_we_in_write", 64'(mem_we), 64'd1);
    chk("nom_addr_in_write", 64'(mem_addr), 64'd1);
    chk("nom_data_in_write", 64'(mem_wdata), 64'hAABBCCDD);
    chk("nom_done_not_yet", 64'(load_done), 64'd0);
    chk("nom_cnt_not_yet", 64'(cantidad_instrucciones), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("nom_done", 64'(load_done), 64'd1);
    chk("nom_cpu_reset", 64'(cpu_reset), 64'd0);
    chk("nom_cantidad", 64'(cantidad_instrucciones), 64'd2);
    chk("nom_in_ready", 64'(in_ready), 64'd0);
    chk("nom_we_low", 64'(mem_we), 64'd0);
    check_writes("nom");

    // Bad header 0x00
    do_reset();
    send(8'h00);
    in_valid = 1'b0;
    chk("hdr00_err", 64'(load_err), 64'd1);
    repeat (6) @(negedge clk);
    chk("hdr00_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("hdr00_in_ready", 64'(in_ready), 64'd0);
    chk("hdr00_nwrites", 64'(wr_data.size()), 64'd0);

    // Bad header 0x80, bytes kept on the bus must be ignored
    do_reset();
    send(8'h80);
    chk("hdr80_err", 64'(load_err), 64'd1);
    in_data = 8'h11;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    chk("hdr80_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("hdr80_done", 64'(load_done), 64'd0);
    chk("hdr80_nwrites", 64'(wr_data.size()), 64'd0);

    // Gappy stream
    do_reset();
    a0 = acc_cnt;
    send(8'h01);
    in_valid = 1'b0;
    foreach (w[i]) begin end
    w = 32'hDEADBEEF;
    for (int b = 3; b >= 0; b--) begin
      repeat (3) @(negedge clk);
      chk("gap_waiting", 64'(load_done), 64'd0);
      send(w[b*8 +: 8]);
      in_valid = 1'b0;
    end
    exp_d.push_back(w);
    repeat (2) @(negedge clk);
    chk("gap_done", 64'(load_done), 64'd1);
    chk("gap_cantidad", 64'(cantidad_instrucciones), 64'd1);
    chk("gap_bytes", 64'(acc_cnt - a0), 64'd5);
    check_writes("gap");

    // Backpressure: N=18 with valid held high throughout
    do_reset();
    a0 = acc_cnt;
    send(8'd18);
    s0 = stall_cnt;
    for (int i = 0; i < 18; i++) send_word($urandom);
    @(negedge clk);
    chk("bp_stalls", 64'(stall_cnt - s0), 64'd18);
    in_valid = 1'b0;
    chk("bp_done", 64'(load_done), 64'd1);
    chk("bp_cantidad", 64'(cantidad_instrucciones), 64'd18);
    chk("bp_bytes", 64'(acc_cnt - a0), 64'd73);
    check_writes("bp");

    // Reset mid-load after the 6th byte
    do_reset();
    send(8'h03);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    exp_d.delete();
    send(8'h01);
    send_word(32'hCAFEF00D);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_cantidad", 64'(cantidad_instrucciones), 64'd1);
    chk("midrst_done", 64'(load_done), 64'd1);
    check_writes("midrst");

    // Maximum size: 127 words, then extra bytes after DONE
    do_reset();
    send(8'h7F);
    for (int i = 0; i < 127; i++) send_word($urandom);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("max_done", 64'(load_done), 64'd1);
    chk("max_cantidad", 64'(cantidad_instrucciones), 64'd127);
    a0 = acc_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(i + 8'h40);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("max_extra_bytes", 64'(acc_cnt - a0), 64'd0);
    chk("max_still_done", 64'(load_done), 64'd1);
    chk("max_cpu_reset", 64'(cpu_reset), 64'd0);
    check_writes("max");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
